// File: rtl/ram_sp_be_clr_if.sv
//------------------------------------------------------------------------------
// ram_sp_be_clr_if : user access bus of the column-enable single-port RAM
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_sp_be_clr_if #(
  parameter int ADR_WD = 8,
  parameter int DAT_WD = 64,
  parameter int COL_WD = 1
);
  localparam int C_NCOL = DAT_WD / COL_WD;

  logic              clr_i;
  logic              clr_busy_o;
  logic              rdy_o;
  logic [ADR_WD-1:0] adr_i;
  logic [C_NCOL-1:0] wr_ena_i;
  logic [DAT_WD-1:0] wr_dat_i;
  logic              rd_ena_i;
  logic              rd_val_o;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              oor_o;

  modport master (
    output clr_i, adr_i, wr_ena_i, wr_dat_i, rd_ena_i,
    input  clr_busy_o, rdy_o, rd_val_o, rd_dat_o, oor_o
  );

  modport slave (
    input  clr_i, adr_i, wr_ena_i, wr_dat_i, rd_ena_i,
    output clr_busy_o, rdy_o, rd_val_o, rd_dat_o, oor_o
  );
endinterface

`default_nettype wire

// File: rtl/ram_sp_be_clr.sv
//------------------------------------------------------------------------------
// ram_sp_be_clr : single-port RAM, column write enables, zero-fill clear engine
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_sp_be_clr #(
  parameter int ADR_WD     = 8,
  parameter int DEPTH      = 192,
  parameter int DAT_WD     = 64,
  parameter int COL_WD     = 1,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic           clk,
  input  logic           rst,
  ram_sp_be_clr_if.slave bus
);

  localparam int                C_NCOL = DAT_WD / COL_WD;
  localparam logic [ADR_WD-1:0] C_LAST = ADR_WD'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADR_WD-1:0] cnt_q;
  logic [DAT_WD-1:0] mem_q [DEPTH];

  logic              w_rdy;
  logic              w_in_rng;
  logic              w_wr_any;
  logic              w_usr_wr;
  logic              w_usr_rd;
  logic              w_oor;
  logic              w_mem_we;
  logic [ADR_WD-1:0] w_mem_adr;
  logic [C_NCOL-1:0] w_mem_col;
  logic [DAT_WD-1:0] w_mem_dat;

  logic [DAT_WD-1:0] rd1_dat_q;
  logic              rd1_val_q;
  logic              oor_q;

  assign w_rdy    = (state_q == ST_IDLE);
  assign w_in_rng = ({1'b0, bus.adr_i} < (ADR_WD + 1)'(DEPTH));
  assign w_wr_any = |bus.wr_ena_i;
  assign w_usr_wr = w_rdy & w_wr_any & w_in_rng;
  // A write wins over a simultaneous read request
  assign w_usr_rd = w_rdy & bus.rd_ena_i & ~w_wr_any & w_in_rng;
  assign w_oor    = w_rdy & (bus.rd_ena_i | w_wr_any) & ~w_in_rng;

  assign bus.rdy_o      = w_rdy;
  assign bus.clr_busy_o = (state_q == ST_CLR);
  assign bus.oor_o      = oor_q;

  always_comb begin
    w_mem_we  = w_usr_wr;
    w_mem_adr = bus.adr_i;
    w_mem_col = bus.wr_ena_i;
    w_mem_dat = bus.wr_dat_i;
    if (state_q == ST_CLR) begin
      w_mem_we  = 1'b1;
      w_mem_adr = cnt_q;
      w_mem_col = '1;
      w_mem_dat = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.clr_i) begin
            state_q <= ST_CLR;
            cnt_q   <= '0;
          end
        end
        ST_CLR: begin
          if (cnt_q == C_LAST) begin
            state_q <= ST_IDLE;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < C_NCOL; k++) begin
        if (w_mem_col[k]) begin
          mem_q[w_mem_adr][k*COL_WD +: COL_WD] <= w_mem_dat[k*COL_WD +: COL_WD];
        end
      end
    end
  end

  // First read stage; data holds between reads so it can drive the port directly
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_dat_q <= '0;
      rd1_val_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      rd1_val_q <= w_usr_rd;
      oor_q     <= w_oor;
      if (w_usr_rd) begin
        rd1_dat_q <= mem_q[bus.adr_i];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DAT_WD-1:0] rd2_dat_q;
    logic              rd2_val_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd2_dat_q <= '0;
        rd2_val_q <= 1'b0;
      end else begin
        rd2_val_q <= rd1_val_q;
        if (rd1_val_q) begin
          rd2_dat_q <= rd1_dat_q;
        end
      end
    end

    assign bus.rd_dat_o = rd2_dat_q;
    assign bus.rd_val_o = rd2_val_q;
  end else begin : g_lat1
    assign bus.rd_dat_o = rd1_dat_q;
    assign bus.rd_val_o = rd1_val_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_be_clr.sv
//------------------------------------------------------------------------------
// tb_ram_sp_be_clr : two instances (bit columns/RD_LAT=1, byte columns/RD_LAT=2)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_sp_be_clr;

  localparam int C_DEPTH = 192;

  typedef struct packed {
    int          due;
    logic [63:0] dat;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] model [C_DEPTH];
  rd_exp_t     q_rd  [2][$];
  int          q_oor [2][$];
  logic [63:0] last  [2];
  logic [1:0]  m_val;
  logic [1:0]  m_oor;
  logic [63:0] m_dat [2];
  rd_exp_t     m_e;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  ram_sp_be_clr_if #(.ADR_WD(8), .DAT_WD(64), .COL_WD(1)) bus_a ();
  ram_sp_be_clr_if #(.ADR_WD(8), .DAT_WD(64), .COL_WD(8)) bus_b ();

  ram_sp_be_clr #(
    .ADR_WD(8), .DEPTH(C_DEPTH), .DAT_WD(64), .COL_WD(1), .RD_LAT(1), .CLR_ON_RST(1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  ram_sp_be_clr #(
    .ADR_WD(8), .DEPTH(C_DEPTH), .DAT_WD(64), .COL_WD(8), .RD_LAT(2), .CLR_ON_RST(1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: read data and oor pulses are matched against the scoreboard
  always @(negedge clk) begin
    if (cyc > 0) begin
      m_val    = {bus_b.rd_val_o, bus_a.rd_val_o};
      m_oor    = {bus_b.oor_o, bus_a.oor_o};
      m_dat[0] = bus_a.rd_dat_o;
      m_dat[1] = bus_b.rd_dat_o;
      for (int i = 0; i < 2; i++) begin
        if (rst_seen) last[i] = '0;
        if (m_val[i]) begin
          if (q_rd[i].size() == 0) begin
            chk_eq($sformatf("rd_val_unexpected[%0d]", i), m_val[i], 1'b0);
          end else begin
            m_e = q_rd[i].pop_front();
            chk_eq($sformatf("rd_cycle[%0d]", i), cyc, m_e.due);
            chk_eq($sformatf("rd_data[%0d]", i), m_dat[i], m_e.dat);
            last[i] = m_e.dat;
          end
        end else begin
          chk_eq($sformatf("rd_hold[%0d]", i), m_dat[i], last[i]);
        end
        while (q_rd[i].size() > 0 && q_rd[i][0].due < cyc) begin
          chk_eq($sformatf("rd_missing_due[%0d]", i), cyc, q_rd[i][0].due);
          void'(q_rd[i].pop_front());
        end
        if (m_oor[i]) begin
          if (q_oor[i].size() == 0) begin
            chk_eq($sformatf("oor_unexpected[%0d]", i), m_oor[i], 1'b0);
          end else begin
            chk_eq($sformatf("oor_cycle[%0d]", i), cyc, q_oor[i].pop_front());
          end
        end
        while (q_oor[i].size() > 0 && q_oor[i][0] < cyc) begin
          chk_eq($sformatf("oor_missing_due[%0d]", i), cyc, q_oor[i][0]);
          void'(q_oor[i].pop_front());
        end
      end
    end
  end

  task automatic idle();
    bus_a.clr_i = 1'b0;  bus_b.clr_i = 1'b0;
    bus_a.adr_i = '0;    bus_b.adr_i = '0;
    bus_a.wr_ena_i = '0; bus_b.wr_ena_i = '0;
    bus_a.wr_dat_i = '0; bus_b.wr_dat_i = '0;
    bus_a.rd_ena_i = 1'b0; bus_b.rd_ena_i = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < C_DEPTH; i++) model[i] = '0;
  endtask

  // One accepted access; expected results are queued with their due cycle
  task automatic access(input int adr, input logic [7:0] be, input logic [63:0] dat,
                        input logic rd);
    logic [63:0] msk;
    rd_exp_t     e;
    for (int i = 0; i < 8; i++) msk[i*8 +: 8] = {8{be[i]}};
    chk_eq("rdy_at_access_a", bus_a.rdy_o, 1'b1);
    chk_eq("rdy_at_access_b", bus_b.rdy_o, 1'b1);
    bus_a.adr_i = adr[7:0];  bus_b.adr_i = adr[7:0];
    bus_a.wr_ena_i = msk;    bus_b.wr_ena_i = be;
    bus_a.wr_dat_i = dat;    bus_b.wr_dat_i = dat;
    bus_a.rd_ena_i = rd;     bus_b.rd_ena_i = rd;
    if (adr < C_DEPTH) begin
      if (be != 8'h00) begin
        model[adr] = (model[adr] & ~msk) | (dat & msk);
      end else if (rd) begin
        e.dat = model[adr];
        e.due = cyc + 1; q_rd[0].push_back(e);
        e.due = cyc + 2; q_rd[1].push_back(e);
      end
    end else if (rd || be != 8'h00) begin
      q_oor[0].push_back(cyc + 1);
      q_oor[1].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic pulse_clr();
    bus_a.clr_i = 1'b1; bus_b.clr_i = 1'b1;
    zero_model();
    @(posedge clk); #1;
    bus_a.clr_i = 1'b0; bus_b.clr_i = 1'b0;
  endtask

  // Counts busy/not-ready cycles; at step poke_at, a clear request plus a
  // write/read to adr 10 is presented and must be ignored.
  task automatic check_clear(input string tag, input int poke_at);
    int na, nb, ra, rb;
    na = 0; nb = 0; ra = 0; rb = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      na += int'(bus_a.clr_busy_o); nb += int'(bus_b.clr_busy_o);
      ra += int'(!bus_a.rdy_o);     rb += int'(!bus_b.rdy_o);
      if (!bus_a.clr_busy_o && !bus_b.clr_busy_o) break;
      if (k == poke_at) begin
        bus_a.clr_i = 1'b1; bus_b.clr_i = 1'b1;
        bus_a.adr_i = 8'd10; bus_b.adr_i = 8'd10;
        bus_a.wr_ena_i = '1; bus_b.wr_ena_i = '1;
        bus_a.wr_dat_i = 64'hDEAD_BEEF_0BAD_F00D; bus_b.wr_dat_i = 64'hDEAD_BEEF_0BAD_F00D;
        bus_a.rd_ena_i = 1'b1; bus_b.rd_ena_i = 1'b1;
      end else begin
        idle();
      end
    end
    idle();
    chk_eq({tag, "_busy_a"}, na, C_DEPTH);
    chk_eq({tag, "_busy_b"}, nb, C_DEPTH);
    chk_eq({tag, "_notrdy_a"}, ra, C_DEPTH);
    chk_eq({tag, "_notrdy_b"}, rb, C_DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  be;
    logic [63:0] d;
    last[0] = '0; last[1] = '0;
    idle();
    zero_model();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_busy_a", bus_a.clr_busy_o, 1'b1);
    chk_eq("rst_busy_b", bus_b.clr_busy_o, 1'b1);
    chk_eq("rst_rdy_a", bus_a.rdy_o, 1'b0);
    chk_eq("rst_rdy_b", bus_b.rdy_o, 1'b0);
    chk_eq("rst_rd_val_a", bus_a.rd_val_o, 1'b0);
    chk_eq("rst_rd_val_b", bus_b.rd_val_o, 1'b0);
    chk_eq("rst_rd_dat_a", bus_a.rd_dat_o, 64'h0);
    chk_eq("rst_rd_dat_b", bus_b.rd_dat_o, 64'h0);
    chk_eq("rst_oor_a", bus_a.oor_o, 1'b0);
    chk_eq("rst_oor_b", bus_b.oor_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_clear("reset_clear", -1);

    access(0, 8'h00, '0, 1'b1);
    access(95, 8'h00, '0, 1'b1);
    access(191, 8'h00, '0, 1'b1);

    // Column write: bytes 0 and 2 take the new data
    access(5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    access(5, 8'h05, 64'h1122_3344_5566_7788, 1'b0);
    access(5, 8'h00, '0, 1'b1);

    // Back-to-back reads, then idle cycles where rd_dat_o must hold
    access(3, 8'hFF, 64'h0303_0303_A5A5_0003, 1'b0);
    access(4, 8'hFF, 64'h0404_0404_5A5A_0004, 1'b0);
    access(5, 8'hFF, 64'h0505_0505_C3C3_0005, 1'b0);
    access(3, 8'h00, '0, 1'b1);
    access(4, 8'h00, '0, 1'b1);
    access(5, 8'h00, '0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end

    // Out-of-range write/read; adr 8 (= 200 mod 192) must be untouched
    access(8, 8'hFF, 64'h8888_0000_1111_2222, 1'b0);
    access(200, 8'hFF, 64'hBADB_ADBA_DBAD_BADB, 1'b0);
    access(200, 8'h00, '0, 1'b1);
    access(8, 8'h00, '0, 1'b1);

    // Read/write collision
    access(7, 8'hFF, 64'h7777_6666_5555_4444, 1'b1);
    access(7, 8'h00, '0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      be = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      d  = {$urandom, $urandom};
      access(int'($urandom_range(0, 199)), be, d, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) access(int'($urandom_range(0, 15)), 8'h00, '0, 1'b1);

    // Read in flight when the clear starts returns pre-clear data
    access(9, 8'hFF, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    access(9, 8'h00, '0, 1'b1);
    pulse_clr();
    check_clear("clr_ignored", 20);
    access(9, 8'h00, '0, 1'b1);
    access(10, 8'h00, '0, 1'b1);
    access(191, 8'h00, '0, 1'b1);

    // Reset at clear cycle 50 restarts the clear from address 0
    access(12, 8'hFF, 64'h1212_1212_1212_1212, 1'b0);
    pulse_clr();
    repeat (49) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_clear("rst_restart", -1);
    access(12, 8'h00, '0, 1'b1);
    access(0, 8'h00, '0, 1'b1);

    repeat (6) begin @(posedge clk); #1; end
    chk_eq("sb_drain_rd_a", q_rd[0].size(), 0);
    chk_eq("sb_drain_rd_b", q_rd[1].size(), 0);
    chk_eq("sb_drain_oor_a", q_oor[0].size(), 0);
    chk_eq("sb_drain_oor_b", q_oor[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
